i2s_delay_sum_beamformer: RTL and testbench

I2S_DELAY_SUM_BEAMFORMER -- requirements
Module: i2s_delay_sum_beamformer

---
 rtl/i2s_delay_sum_beamformer.sv | 157 +++++++++++++++
 tb/tb_i2s_delay_sum_beamformer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_delay_sum_beamformer.sv
// Delay-and-sum beamformer: deserialises NUM_PAIRS stereo I2S inputs, delays each
// channel by a programmable number of frames and emits their floor average.
module i2s_delay_sum_beamformer #(
  parameter int NUM_PAIRS    = 2,
  parameter int SAMPLE_WIDTH = 8,
  parameter int SLOT_BITS    = 16,
  parameter int DEPTH        = 8,
  localparam int NCH         = 2 * NUM_PAIRS,
  localparam int CW          = $clog2(NCH),
  localparam int DW          = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PAIRS-1:0]    sd_in,
  input  logic                    cfg_we,
  input  logic [CW:0]             cfg_ch,
  input  logic [DW-1:0]           cfg_delay,
  input  logic                    cfg_mask,
  output logic                    ws,
  output logic                    sd_out,
  output logic [SAMPLE_WIDTH-1:0] sum_out,
  output logic                    sum_valid
);

  localparam int BCW   = $clog2(2 * SLOT_BITS);
  localparam int ACC_W = SAMPLE_WIDTH + CW;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [SAMPLE_WIDTH-1:0] MSB_ONE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  logic [BCW-1:0]          bc_q, bc_d;
  logic [DW-1:0]           wptr_q, wptr_d;
  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           ch_q, ch_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [SAMPLE_WIDTH-1:0] cap_q [NCH];
  logic [SAMPLE_WIDTH-1:0] cap_d [NCH];
  logic [SAMPLE_WIDTH-1:0] mem_q [DEPTH][NCH];
  logic [SAMPLE_WIDTH-1:0] mem_d [DEPTH][NCH];
  logic [DW-1:0]           delay_q [NCH];
  logic [DW-1:0]           delay_d [NCH];
  logic [NCH-1:0]          mask_q, mask_d;
  logic [SAMPLE_WIDTH-1:0] sum_q, sum_d;
  logic [SAMPLE_WIDTH-1:0] out_q, out_d;

  logic [BCW-1:0]          pos;
  logic                    frame_end;
  logic                    in_sample;
  logic [DW-1:0]           rd_addr;
  logic [SAMPLE_WIDTH-1:0] rd_sample;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] acc_sum;
  logic [SAMPLE_WIDTH-1:0] bit_sel;

  assign ws        = bc_q >= BCW'(SLOT_BITS);
  assign pos       = ws ? bc_q - BCW'(SLOT_BITS) : bc_q;
  assign frame_end = bc_q == BCW'(2 * SLOT_BITS - 1);
  assign in_sample = (pos >= BCW'(1)) && (pos <= BCW'(SAMPLE_WIDTH));

  // wptr_q has already advanced past the frame just written, hence the extra -1.
  assign rd_addr   = wptr_q - DW'(1) - delay_q[ch_q];
  assign rd_sample = mem_q[rd_addr][ch_q];
  assign addend    = mask_q[ch_q] ? '0
                   : {{CW{rd_sample[SAMPLE_WIDTH-1]}}, rd_sample};
  assign acc_sum   = acc_q + addend;

  // The held word is replayed MSB-first in both slots of the frame.
  assign bit_sel   = MSB_ONE >> (pos - BCW'(1));
  assign sd_out    = in_sample & (|(out_q & bit_sel));
  assign sum_out   = sum_q;
  assign sum_valid = state_q == DONE;

  always_comb begin
    // NOTE: every _d gets its default first, so no path can infer a latch.
    bc_d    = frame_end ? '0 : bc_q + BCW'(1);
    wptr_d  = wptr_q;
    state_d = state_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    cap_d   = cap_q;
    mem_d   = mem_q;
    delay_d = delay_q;
    mask_d  = mask_q;
    sum_d   = sum_q;
    out_d   = (bc_q == '0) ? sum_q : out_q;

    if (in_sample) begin
      for (int p = 0; p < NUM_PAIRS; p++) begin
        if (ws) cap_d[2*p+1] = {cap_q[2*p+1][SAMPLE_WIDTH-2:0], sd_in[p]};
        else    cap_d[2*p]   = {cap_q[2*p][SAMPLE_WIDTH-2:0], sd_in[p]};
      end
    end

    if (frame_end) begin
      for (int c = 0; c < NCH; c++) mem_d[wptr_q][c] = cap_q[c];
      wptr_d = wptr_q + DW'(1);
    end

    case (state_q)
      IDLE: begin
        if (frame_end) begin
          state_d = ACCUM;
          ch_d    = '0;
          acc_d   = '0;
        end
      end
      ACCUM: begin
        acc_d = acc_sum;
        ch_d  = ch_q + CW'(1);
        if (ch_q == CW'(NCH - 1)) begin
          state_d = DONE;
          // Arithmetic shift by CW then truncation == the top SAMPLE_WIDTH bits.
          sum_d   = acc_sum[ACC_W-1:CW];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (cfg_we && (cfg_ch < (CW+1)'(NCH))) begin
      delay_d[cfg_ch[CW-1:0]] = cfg_delay;
      mask_d[cfg_ch[CW-1:0]]  = cfg_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc_q    <= '0;
      wptr_q  <= '0;
      state_q <= IDLE;
      ch_q    <= '0;
      acc_q   <= '0;
      cap_q   <= '{default: '0};
      // NOTE: the delay line is a flop array with reset so stale frames never leak out after reset.
      mem_q   <= '{default: '0};
      delay_q <= '{default: '0};
      mask_q  <= '0;
      sum_q   <= '0;
      out_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
      bc_q    <= bc_d;
      wptr_q  <= wptr_d;
      state_q <= state_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      cap_q   <= cap_d;
      mem_q   <= mem_d;
      delay_q <= delay_d;
      mask_q  <= mask_d;
      sum_q   <= sum_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_i2s_delay_sum_beamformer.sv
// Bench for i2s_delay_sum_beamformer: frame-level model built from per-frame sample
// history, directed vectors/sequences and randomized frames with random config writes.
module tb_i2s_delay_sum_beamformer;

  localparam int NUM_PAIRS = 2;
  localparam int SW        = 8;
  localparam int SLOT_BITS = 16;
  localparam int DEPTH     = 8;
  localparam int NCH       = 2 * NUM_PAIRS;
  localparam int FRAME     = 2 * SLOT_BITS;
  localparam int CHW       = $clog2(NCH) + 1;
  localparam int DW        = $clog2(DEPTH);
  localparam int MAXF      = 64;

  typedef logic [NCH-1:0][SW-1:0] frame_t;
  typedef struct { int ch; int dly; int msk; int at_b; } cfg_t;
  typedef struct { frame_t s; logic [SW-1:0] exp_sum; } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NUM_PAIRS-1:0] sd_in = '0;
  logic                 cfg_we = 1'b0;
  logic [CHW-1:0]       cfg_ch = '0;
  logic [DW-1:0]        cfg_delay = '0;
  logic                 cfg_mask = 1'b0;
  logic                 ws, sd_out, sum_valid;
  logic [SW-1:0]        sum_out;

  always #5 clk = ~clk;

  i2s_delay_sum_beamformer #(
    .NUM_PAIRS(NUM_PAIRS), .SAMPLE_WIDTH(SW), .SLOT_BITS(SLOT_BITS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sd_in(sd_in), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_delay(cfg_delay), .cfg_mask(cfg_mask), .ws(ws), .sd_out(sd_out),
    .sum_out(sum_out), .sum_valid(sum_valid)
  );

  int            checks = 0;
  int            failures = 0;
  frame_t        hist [MAXF];
  logic [SW-1:0] sums_seen [MAXF];
  logic [SW-1:0] sd_seen [MAXF];
  int            frame_no = 0;
  int            exp_sd = 0;
  int            m_delay [NCH];
  int            m_mask [NCH];
  cfg_t          cfg_q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Average of every unmasked channel's sample from (delay+1) frames ago, rounded down.
  function automatic int model_sum(input int f, input int dly [NCH], input int msk [NCH]);
    int total = 0;
    int src, v, q;
    for (int c = 0; c < NCH; c++) begin
      if (msk[c] != 0) continue;
      src = f - 1 - dly[c];
      v = (src >= 0) ? int'(hist[src][c]) : 0;
      if (v >= (1 << (SW - 1))) v -= (1 << SW);
      total += v;
    end
    q = total / NCH;
    if (total < 0 && (total % NCH) != 0) q--;
    return q & ((1 << SW) - 1);
  endfunction

  task automatic do_reset();
    sd_in  = '0;
    cfg_we = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    frame_no = 0;
    exp_sd   = 0;
    for (int c = 0; c < NCH; c++) begin
      m_delay[c] = 0;
      m_mask[c]  = 0;
    end
    cfg_q.delete();
  endtask

  // Runs one 32-clock frame starting at bc=0, checking everything observed in it.
  task automatic run_frame(input frame_t s);
    int            used_dly [NCH];
    int            used_msk [NCH];
    int            valid_cnt = 0;
    int            ws_bad = 0;
    int            sd_bad = 0;
    int            pos, exp_sum;
    logic [SW-1:0] got_sum = '0;
    logic [SW-1:0] left_w = '0;
    logic [SW-1:0] right_w = '0;
    logic [SW-1:0] tmp;
    cfg_t          c;
    for (int c2 = 0; c2 < NCH; c2++) begin
      used_dly[c2] = 0;
      used_msk[c2] = 0;
    end
    for (int b = 0; b < FRAME; b++) begin
      pos = b % SLOT_BITS;
      if (sum_valid === 1'b1) begin
        valid_cnt++;
        got_sum = sum_out;
      end else if (sum_valid !== 1'b0) valid_cnt += 100;
      if (ws !== (b >= SLOT_BITS)) ws_bad++;
      if (pos >= 1 && pos <= SW) begin
        if (b < SLOT_BITS) left_w[SW-pos] = sd_out;
        else               right_w[SW-pos] = sd_out;
      end else if (sd_out !== 1'b0) sd_bad++;
      // Channel b is summed in cycle b using the config held before this cycle's write.
      if (b < NCH) begin
        used_dly[b] = m_delay[b];
        used_msk[b] = m_mask[b];
      end
      sd_in = '0;
      if (pos >= 1 && pos <= SW) begin
        for (int p = 0; p < NUM_PAIRS; p++) begin
          tmp = s[2*p + ((b >= SLOT_BITS) ? 1 : 0)];
          sd_in[p] = tmp[SW-pos];
        end
      end
      cfg_we = 1'b0;
      if (cfg_q.size() > 0 && cfg_q[0].at_b == b) begin
        c = cfg_q.pop_front();
        cfg_we    = 1'b1;
        cfg_ch    = CHW'(c.ch);
        cfg_delay = DW'(c.dly);
        cfg_mask  = c.msk[0];
        if (c.ch < NCH) begin
          m_delay[c.ch] = c.dly;
          m_mask[c.ch]  = c.msk;
        end
      end
      @(negedge clk);
    end
    cfg_we = 1'b0;
    exp_sum = 0;
    if (frame_no == 0) begin
      check("valid_pulses f0", valid_cnt, 0);
    end else begin
      exp_sum = model_sum(frame_no, used_dly, used_msk);
      check($sformatf("valid_pulses f%0d", frame_no), valid_cnt, 1);
      check($sformatf("sum_out f%0d", frame_no), got_sum, exp_sum);
    end
    check($sformatf("ws_pattern f%0d", frame_no), ws_bad, 0);
    check($sformatf("sd_left f%0d", frame_no), left_w, exp_sd);
    check($sformatf("sd_right f%0d", frame_no), right_w, exp_sd);
    check($sformatf("sd_idle_bits f%0d", frame_no), sd_bad, 0);
    hist[frame_no]      = s;
    sums_seen[frame_no] = got_sum;
    sd_seen[frame_no]   = left_w;
    exp_sd   = (frame_no == 0) ? 0 : exp_sum;
    frame_no = frame_no + 1;
  endtask

  initial begin
    vec_t   vecs [6];
    frame_t fr;
    cfg_t   cw;

    vecs[0] = '{s: 32'h40404040, exp_sum: 8'h40};
    vecs[1] = '{s: 32'h80808080, exp_sum: 8'h80};
    vecs[2] = '{s: 32'h80807F7F, exp_sum: 8'hFF};
    vecs[3] = '{s: 32'h04030201, exp_sum: 8'h02};
    vecs[4] = '{s: 32'hFEFFFFFF, exp_sum: 8'hFE};
    vecs[5] = '{s: 32'h7F7F7F7F, exp_sum: 8'h7F};

    #1 rst_n = 1'b0;
    #1;
    check("reset sum_out", sum_out, 0);
    check("reset sum_valid", sum_valid, 0);
    check("reset sd_out", sd_out, 0);
    check("reset ws", ws, 0);

    // Constant-input vectors with all delays 0: the frame after the data shows the average.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].s);
      run_frame(vecs[i].s);
      check($sformatf("table sum vec%0d", i), sums_seen[frame_no-1], vecs[i].exp_sum);
    end
    check("table sd 0x40", sd_seen[2], 8'h40);

    // Impulse on channel 0 in frame 5 with delay 3.
    do_reset();
    cfg_q.push_back('{ch: 0, dly: 3, msk: 0, at_b: 10});
    for (int f = 0; f <= 10; f++) begin
      fr = (f == 5) ? frame_t'(32'h0000007F) : frame_t'(32'h0);
      run_frame(fr);
    end
    check("impulse sum f9", sums_seen[9], 8'h1F);
    check("impulse sum f8", sums_seen[8], 8'h00);
    check("impulse sum f10", sums_seen[10], 8'h00);
    check("impulse sd f10", sd_seen[10], 8'h1F);

    // Mask on channel 1; write to channel 4 must be ignored.
    do_reset();
    cfg_q.push_back('{ch: 1, dly: 0, msk: 1, at_b: 10});
    cfg_q.push_back('{ch: 4, dly: 5, msk: 1, at_b: 11});
    for (int f = 0; f < 4; f++) run_frame(frame_t'(32'h00007F00));
    run_frame(frame_t'(32'h00000040));
    run_frame(frame_t'(32'h0));
    check("mask sum f2", sums_seen[2], 8'h00);
    check("mask sum f3", sums_seen[3], 8'h00);
    check("cfg_ch4 ignored f5", sums_seen[5], 8'h10);

    // Delay DEPTH-1 on every channel, stream 1..16: the write pointer wraps twice.
    do_reset();
    for (int c = 0; c < NCH; c++) cfg_q.push_back('{ch: c, dly: DEPTH - 1, msk: 0, at_b: 10 + c});
    for (int f = 0; f < 23; f++) begin
      fr = (f < 16) ? {NCH{8'(f + 1)}} : frame_t'(32'h0);
      run_frame(fr);
    end
    check("stream sum f7", sums_seen[7], 8'h00);
    check("stream sum f8", sums_seen[8], 8'h01);
    check("stream sum f15", sums_seen[15], 8'h08);
    check("stream sum f22", sums_seen[22], 8'h0F);

    // Asynchronous reset in the middle of frame 23 at bc=20.
    sd_in = '1;
    repeat (20) @(negedge clk);
    check("pre-reset ws", ws, 1);
    check("pre-reset sum_out", sum_out, 8'h10);
    rst_n = 1'b0;
    #1;
    check("mid reset sum_out", sum_out, 0);
    check("mid reset sum_valid", sum_valid, 0);
    check("mid reset sd_out", sd_out, 0);
    check("mid reset ws", ws, 0);
    do_reset();
    for (int c = 0; c < NCH; c++) cfg_q.push_back('{ch: c, dly: DEPTH - 1, msk: 0, at_b: 10 + c});
    for (int f = 0; f < 9; f++) begin
      for (int c = 0; c < NCH; c++) fr[c] = 8'($urandom_range(1, 127));
      run_frame(fr);
    end
    for (int f = 1; f < 8; f++) check($sformatf("cleared line f%0d", f), sums_seen[f], 8'h00);

    // Randomized frames with random config writes anywhere in the frame, incl. frame end.
    cfg_q.push_back('{ch: 2, dly: 1, msk: 0, at_b: 31});
    for (int f = 0; f < 30; f++) begin
      if (f > 0 && $urandom_range(0, 1) == 1) begin
        cw = '{ch: int'($urandom_range(0, 7)), dly: int'($urandom_range(0, DEPTH - 1)),
               msk: ($urandom_range(0, 3) == 0) ? 1 : 0, at_b: int'($urandom_range(0, 15))};
        cfg_q.push_back(cw);
      end
      if ($urandom_range(0, 1) == 1) begin
        cw = '{ch: int'($urandom_range(0, 7)), dly: int'($urandom_range(0, DEPTH - 1)),
               msk: ($urandom_range(0, 3) == 0) ? 1 : 0, at_b: int'($urandom_range(16, 31))};
        cfg_q.push_back(cw);
      end
      fr = frame_t'($urandom);
      run_frame(fr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
